// File: rtl/online_sd_adder.sv
// ============================================================================
//  Module   : online_sd_adder
//  Purpose  : MSD-first radix-2 signed-digit online adder/subtractor (delay 2)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module online_sd_adder #(
   parameter int NDIGITS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       sub,
   input  logic       in_valid,
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic       busy,
   output logic       out_valid,
   output logic       zp,
   output logic       zn,
   output logic       out_first,
   output logic       out_last
);

   localparam int CNT_W = $clog2(NDIGITS + 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIGITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              sub_q;
   logic signed [2:0] g_q;
   logic              e_q;

   logic              accept;
   logic              step;
   logic [1:0]        y_eff;
   logic signed [2:0] dx;
   logic signed [2:0] dy;
   logic signed [2:0] a;
   logic              h;
   logic signed [2:0] g;
   logic signed [2:0] v;
   logic              t_neg;
   logic              e;
   logic              zp_d;
   logic              zn_d;

   assign accept = (state == RUN) && in_valid;
   assign step   = accept || (state == FLUSH);
   assign busy   = (state != IDLE);

   always_comb begin
      dx    = 3'sd0;
      dy    = 3'sd0;
      y_eff = sub_q ? {y[0], y[1]} : y;
      // Flush steps feed zero digits, so the decoders only look at RUN inputs.
      if (state == RUN) begin
         case (x)
            2'b10:   dx = 3'sd1;
            2'b01:   dx = 3'sb111;
            default: dx = 3'sd0;
         endcase
         case (y_eff)
            2'b10:   dy = 3'sd1;
            2'b01:   dy = 3'sb111;
            default: dy = 3'sd0;
         endcase
      end
      a     = dx + dy;
      h     = (a > 3'sd0);
      g     = h ? (a - 3'sd2) : a;
      v     = g_q + $signed({2'b00, h});
      t_neg = (v < 3'sd0);
      e     = (v == 3'sd1) || (v == 3'sb111);
      // z = e(previous position) + t(this position), always in {-1,0,+1}
      zp_d  = e_q & ~t_neg;
      zn_d  = ~e_q & t_neg;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (in_valid && (cnt == LAST_DIGIT)) state_nxt = FLUSH;
         FLUSH:   if (cnt == CNT_ONE) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         sub_q     <= 1'b0;
         g_q       <= 3'sd0;
         e_q       <= 1'b0;
         out_valid <= 1'b0;
         zp        <= 1'b0;
         zn        <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         zp        <= 1'b0;
         zn        <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         if ((state == IDLE) && start) begin
            cnt   <= '0;
            sub_q <= sub;
            g_q   <= 3'sd0;
            e_q   <= 1'b0;
         end else if (step) begin
            g_q <= g;
            e_q <= e;
            if (state == RUN) cnt <= (cnt == LAST_DIGIT) ? '0 : cnt + CNT_ONE;
            else              cnt <= cnt + CNT_ONE;
            // Digit 1 only primes the transfer pipeline; every later step emits.
            if ((state == FLUSH) || (cnt != '0)) begin
               out_valid <= 1'b1;
               zp        <= zp_d;
               zn        <= zn_d;
            end
            out_first <= accept && (cnt == CNT_ONE);
            out_last  <= (state == FLUSH) && (cnt == CNT_ONE);
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/online_sd_adder.md
Name: online_sd_adder

Overview:
- Digit-serial, most-significant-digit-first (online) radix-2 signed-digit adder/subtractor with online delay 2.
- Carry-free two-level transfer scheme; each operand is an NDIGITS fraction, one digit per accepted cycle.
- Result is NDIGITS+1 digits: an integer digit z0 followed by fraction digits z1..zN.
- Serial companion to the parallel redundant adder cells; it feeds the online multiplier/accumulator chain.

Parameters:
- NDIGITS, 8, operand fraction digits, index i=1..N with weight 2^-i; legal range is NDIGITS >= 2.
- CNT_W, $clog2(NDIGITS+1), width of the digit counter; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins an operation; honoured only in IDLE
- sub  in  1  0 = X+Y, 1 = X-Y; sampled with start, held for the whole operation
- in_valid  in  1  operand digit pair present; honoured only in RUN
- x  in  2  digit of X as {p,n}, value p-n; 11 is treated as 0
- y  in  2  digit of Y, same encoding
- busy  out  1  high in RUN and FLUSH
- out_valid  out  1  zp/zn carry a result digit this cycle
- zp  out  1  result digit positive bit
- zn  out  1  result digit negative bit
- out_first  out  1  high with z0
- out_last  out  1  high with zN

Behaviour:
- Reset, asynchronous: state IDLE, counter 0, all transfer registers 0, and every output (busy, out_valid, zp, zn, out_first, out_last) 0.
- Reset asserted mid-operation aborts it immediately; no partial digits appear after release.
- Output encoding is canonical: +1=10, -1=01, 0=00. zp/zn are 00 whenever out_valid=0.
- Subtraction: when sub=1, each y digit is negated (p and n swapped) before addition.
- Digit rule, applied at position i:
  - a_i = x_i + y'_i, range [-2,2].
  - Level 1 gives h_i in {0,1} and g_i in {-2,-1,0} with a_i = 2h_i + g_i:
    - a=-2 -> (0,-2)
    - a=-1 -> (0,-1)
    - a=0 -> (0,0)
    - a=1 -> (1,-1)
    - a=2 -> (1,0)
  - v_i = g_i + h_{i+1}, range [-2,1].
  - Level 2 gives t_i in {-1,0} and e_i in {0,1} with v_i = 2t_i + e_i:
    - v=-2 -> (-1,0)
    - v=-1 -> (-1,1)
    - v=0 -> (0,0)
    - v=1 -> (0,1)
  - z_i = e_i + t_{i+1}, always in {-1,0,1}.
  - Position 0: g_0=0, t_0=0.
  - Positions beyond N take zero digits.
  - Guarantee: sum of z_i*2^-i over i=0..N equals X±Y exactly; no overflow is possible since |X±Y|<2.
- FSM:
  - IDLE -> RUN on start. The start edge clears the counter and transfer registers and latches sub.
  - RUN: each rising edge with in_valid=1 accepts digit k (k=1..N). Cycles with in_valid=0 are stalls: no state change, out_valid=0.
  - RUN -> FLUSH on acceptance of digit N.
  - FLUSH: two automatic steps with zero inputs, no stalls allowed, then -> IDLE.
- Latency:
  - The edge accepting digit k (k>=2) registers z_{k-2}; out_valid=1 in the following cycle.
  - Digit 1 produces no output.
  - Flush edges 1 and 2 register z_{N-1} and z_N, on consecutive cycles.
  - out_first accompanies z0; out_last accompanies zN.
  - busy falls in the same cycle out_last is shown.
- Throughput: N+1 output digits per operation. A new start is accepted in the out_last cycle (state is already IDLE).
- Ignored inputs:
  - start while busy: no effect.
  - in_valid in IDLE or FLUSH: no effect.
  - sub changes after start: no effect.

Test Plan:
- NDIGITS=4, sub=0, x=y=+1 on all digits, no stalls -> z0..z4 = +1,+1,+1,+1,0 (1.875). out_valid first appears the cycle after digit 2 is accepted. out_first is on z0 and out_last on z4, 3 cycles after digit 4 is accepted.
- NDIGITS=4, x=y=-1 on all digits -> z = -1,-1,-1,-1,0 (-1.875). Then x=+1, y=-1 on all digits -> z = 0,0,0,0,0. Also apply 11 on x with y=00 -> all-zero result.
- NDIGITS=4, sub=1, x=y=(+1,-1,0,+1) -> z = 0,0,0,0,0. Toggle sub mid-operation -> result unchanged.
- Random X,Y with random in_valid gaps (0-3 stall cycles), random sub, 10k operations -> the value of z0..zN equals the reference sum exactly, every z is legal, and out_valid count per operation is N+1.
- Pulse start while busy and drive in_valid in FLUSH/IDLE -> ignored; digit stream is identical to the clean run. Issue back-to-back start in the out_last cycle -> second operation is correct.
- Drop rst_n after digit 3 of 4 -> all outputs 0 asynchronously. After release with no start, out_valid stays 0. A fresh operation is then correct.
